// File: rtl/registered_selector_n.sv
// Registered N-input selector: select code latched on Load, output tracks or holds the chosen source.
// Optional macro SELECTOR_RANGE_CHECK_EN adds an ERROR state and a sticky SelError for out-of-range codes.
module registered_selector_n #(
    parameter int WIDTH      = 5,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                        Clk,
    input  logic                        RstN,
    input  logic [NUM_INPUTS*WIDTH-1:0] DataInputs,
    input  logic [SEL_WIDTH-1:0]        Control,
    input  logic                        Load,
    input  logic                        Hold,
    input  logic                        Flush,
    output logic [WIDTH-1:0]            DataOutput,
    output logic                        Valid,
    output logic                        SelError,
    output logic [1:0]                  DbgState
);

`ifdef SELECTOR_RANGE_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, ERROR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1} state_t;
`endif

    state_t                 state_q;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [WIDTH-1:0]       data_q;
    logic                   valid_q;
    logic [WIDTH-1:0]       ctrl_data_d;
    logic [WIDTH-1:0]       track_data_d;
    logic [WIDTH-1:0]       in0_data_d;
    logic                   ctrl_ok_d;

    // Codes without a matching source decode to zero, so DataOutput never sees X.
    function automatic logic [WIDTH-1:0] pick(input logic [NUM_INPUTS*WIDTH-1:0] din,
                                              input logic [SEL_WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (s == SEL_WIDTH'(k)) r = din[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    always_comb begin
        ctrl_data_d  = pick(DataInputs, Control);
        track_data_d = pick(DataInputs, sel_q);
        in0_data_d   = DataInputs[WIDTH-1:0];
        ctrl_ok_d    = (int'(Control) < NUM_INPUTS);
    end

`ifdef SELECTOR_RANGE_CHECK_EN
    logic err_q;
`endif

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef SELECTOR_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (Flush) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef SELECTOR_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (Load) begin
            if (ctrl_ok_d) begin
                state_q <= TRACK;
                sel_q   <= Control;
                data_q  <= ctrl_data_d;
                valid_q <= 1'b1;
`ifdef SELECTOR_RANGE_CHECK_EN
                err_q   <= 1'b0;
`endif
            end else begin
`ifdef SELECTOR_RANGE_CHECK_EN
                state_q <= ERROR;
                sel_q   <= Control;
                data_q  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b1;
`else
                // Without range checking an illegal code falls back to source 0.
                state_q <= TRACK;
                sel_q   <= '0;
                data_q  <= in0_data_d;
                valid_q <= 1'b1;
`endif
            end
        end else begin
            case (state_q)
                TRACK: if (!Hold) data_q <= track_data_d;
                default: ;
            endcase
        end
    end

    assign DataOutput = data_q;
    assign Valid      = valid_q;
    assign DbgState   = state_q;
`ifdef SELECTOR_RANGE_CHECK_EN
    assign SelError   = err_q;
`else
    assign SelError   = 1'b0;
`endif

endmodule

// File: tb/tb_registered_selector_n.sv
// Bench for registered_selector_n (3 sources of 5 bits, 2-bit code so code 3 is out of range).
// Scoreboard of expected {data, valid, err} per cycle, popped by an independent monitor.
module tb_registered_selector_n;
    localparam int W  = 5;
    localparam int N  = 3;
    localparam int SW = 2;

    logic            Clk;
    logic            RstN;
    logic [N*W-1:0]  DataInputs;
    logic [SW-1:0]   Control;
    logic            Load;
    logic            Hold;
    logic            Flush;
    logic [W-1:0]    DataOutput;
    logic            Valid;
    logic            SelError;
    logic [1:0]      DbgState;

    registered_selector_n #(.WIDTH(W), .NUM_INPUTS(N), .SEL_WIDTH(SW)) dut (
        .Clk(Clk), .RstN(RstN), .DataInputs(DataInputs), .Control(Control),
        .Load(Load), .Hold(Hold), .Flush(Flush), .DataOutput(DataOutput),
        .Valid(Valid), .SelError(SelError), .DbgState(DbgState)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];

    // reference model in spec terms
    int  src[N];
    int  m_sel;
    int  m_data;
    bit  m_valid;
    bit  m_err;
    bit  m_tracking;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_data = 0; m_valid = 0; m_err = 0; m_tracking = 0;
    endtask

    task automatic apply_inputs();
        for (int k = 0; k < N; k++) DataInputs[k*W +: W] = W'(src[k]);
    endtask

    // driver: one cycle of stimulus, model advanced, expectation queued
    task automatic step(input bit ld, input int ctrl, input bit hd, input bit fl);
        @(negedge Clk);
        apply_inputs();
        Load = ld; Control = SW'(ctrl); Hold = hd; Flush = fl;
        if (fl) begin
            model_reset();
        end else if (ld) begin
            if (ctrl < N) begin
                m_sel = ctrl; m_data = src[ctrl]; m_valid = 1; m_err = 0; m_tracking = 1;
            end else begin
`ifdef SELECTOR_RANGE_CHECK_EN
                m_sel = ctrl; m_data = 0; m_valid = 0; m_err = 1; m_tracking = 0;
`else
                m_sel = 0; m_data = src[0]; m_valid = 1; m_err = 0; m_tracking = 1;
`endif
            end
        end else if (m_tracking && !hd) begin
            m_data = src[m_sel];
        end
        exp_q.push_back({W'(m_data), m_valid, m_err});
    endtask

    // monitor
    initial begin
        logic [W+1:0] e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data",  int'(DataOutput), int'(e[W+1:2]));
                check("valid", int'(Valid),      int'(e[1]));
                check("err",   int'(SelError),   int'(e[0]));
            end
        end
    end

    task automatic async_reset_check();
        @(posedge Clk);
        #3;
        RstN = 1'b0;
        #1;
        model_reset();
        check("rst_data",  int'(DataOutput), m_data);
        check("rst_valid", int'(Valid),      int'(m_valid));
        check("rst_err",   int'(SelError),   int'(m_err));
        @(negedge Clk);
        Load = 0; Flush = 0; Hold = 0;
        RstN = 1'b1;
    endtask

    initial begin
        RstN = 1'b0; Load = 0; Hold = 0; Flush = 0; Control = '0;
        src[0] = 5'h03; src[1] = 5'h15; src[2] = 5'h0A;
        apply_inputs();
        model_reset();
        #3;
        check("reset_data",  int'(DataOutput), 0);
        check("reset_valid", int'(Valid),      0);
        check("reset_err",   int'(SelError),   0);
        @(negedge Clk);
        RstN = 1'b1;

        // directed sequence
        step(0, 0, 0, 0);
        step(1, 2, 0, 0);
        src[2] = 5'h11; step(0, 0, 0, 0);
        src[2] = 5'h07; step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 1);
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        step(1, 3, 0, 0);
        src[0] = 5'h1E; step(0, 0, 1, 0);
        src[0] = 5'h04; step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 2, 0, 0);
        src[2] = 5'h19; step(0, 0, 0, 0);
        async_reset_check();
        src[1] = 5'h0F; step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit ld, hd, fl;
            int ctrl;
            if ($urandom_range(0, 1) == 1) src[$urandom_range(0, N-1)] = int'($urandom_range(0, 31));
            fl   = ($urandom_range(0, 19) == 0);
            ld   = ($urandom_range(0, 4) == 0);
            hd   = ($urandom_range(0, 2) == 0);
            ctrl = int'($urandom_range(0, 3));
            step(ld, ctrl, hd, fl);
            if (i == 200) async_reset_check();
        end
        step(0, 0, 0, 0);

        repeat (3) @(posedge Clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/registered_selector_n.md
# registered_selector_n

Parametrised, registered N-input selector for the multicycle datapath. It generalises the fixed 5-bit 2:1 selector to WIDTH-bit data and NUM_INPUTS sources. The select code is latched on a load strobe and held across the multicycle states, and the output is registered with hold, flush and a valid flag. It sits between the register-file/ALU result sources and the stage registers, so select codes issued by the control FSM need only be valid for the load cycle.

## Interface
- WIDTH, default 5: data width of each input and of the output.
- NUM_INPUTS, default 4: number of selectable inputs; must be ≥2.
- SEL_WIDTH, default 2: select code width; must satisfy 2^SEL_WIDTH ≥ NUM_INPUTS.
- Clk  input  1  clock; all state updates on the rising edge.
- RstN  input  1  asynchronous, active-low reset.
- DataInputs  input  NUM_INPUTS*WIDTH  packed sources; input k occupies bits [k*WIDTH +: WIDTH].
- Control  input  SEL_WIDTH  select code; sampled only when Load=1.
- Load  input  1  capture Control and load the output.
- Hold  input  1  freeze DataOutput while tracking.
- Flush  input  1  synchronous return to idle.
- DataOutput  output  WIDTH  registered selected data.
- Valid  output  1  DataOutput holds data from a valid selection.
- SelError  output  1  sticky out-of-range select flag.

## Operation
- Internal state: the 2-bit FSM {IDLE, TRACK, ERROR} and SelReg[SEL_WIDTH-1:0].
- Command priority per cycle: Flush > Load > Hold.
- Flush (any state): next state is IDLE. DataOutput←0, Valid←0, SelError←0, SelReg←0.
- Load with Control < NUM_INPUTS (any state): SelReg←Control, DataOutput←input[Control] as sampled this cycle, Valid←1, SelError←0, next state TRACK.
- Load with Control ≥ NUM_INPUTS (any state): SelReg←Control, DataOutput←0, Valid←0, SelError←1, next state ERROR. This is the range-check behaviour; see Configuration.
- IDLE, no command: all outputs hold their current values. After reset these are 0.
- TRACK, no Load/Flush:
  - With Hold=0, DataOutput←input[SelReg] every cycle, following the inputs with a one-cycle delay.
  - With Hold=1, DataOutput keeps its value.
  - Valid stays 1 in both cases.
- ERROR: DataOutput stays 0, Valid stays 0 and SelError stays 1 until a Load or Flush. Hold has no effect.
- A Load always overrides Hold in the same cycle.
- Unused select codes never produce X on DataOutput.

## Timing
- Reset (RstN=0, asynchronous): DataOutput=0, Valid=0, SelError=0, SelReg=0, state IDLE. All outputs take effect immediately, without waiting for Clk.
- Deassertion of RstN is used synchronously; the first command is accepted on the first rising edge with RstN=1.
- Latency: Load in cycle N → DataOutput, Valid and SelError updated after edge N (visible in cycle N+1).
- Tracking latency: an input change in cycle M appears on DataOutput in cycle M+1.
- Back-to-back Loads: each Load takes effect at its own edge. No dead cycle is needed.
- Reset asserted mid-TRACK: outputs clear asynchronously and tracking stops. Operation resumes only on a new Load.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro SELECTOR_RANGE_CHECK_EN.
- Defined: out-of-range handling as described above, including the ERROR state and the SelError flag.
- Undefined:
  - The ERROR state is not built and SelError is tied to 0.
  - An out-of-range Load behaves as a valid Load of input 0, with SelReg←0, Valid←1 and next state TRACK.
- When NUM_INPUTS = 2^SEL_WIDTH, both builds behave identically.

## Test plan
- Reset, then WIDTH=5, NUM_INPUTS=4 with inputs {3:5'h1C, 2:5'h0A, 1:5'h15, 0:5'h03}; Load with Control=2 → next cycle DataOutput=5'h0A, Valid=1, SelError=0.
- While tracking, change input 2 to 5'h11 → DataOutput=5'h11 one cycle later. Assert Hold, then change input 2 to 5'h07 → DataOutput stays 5'h11 until Hold drops, then shows 5'h07.
- Load and Flush in the same cycle → Flush wins: DataOutput=0, Valid=0, state IDLE. Then Load with Control=3 and Hold=1 in the same cycle → DataOutput=5'h1C.
- NUM_INPUTS=3, Load with Control=3:
  - With SELECTOR_RANGE_CHECK_EN defined → DataOutput=0, Valid=0, SelError=1, held until the next Load of Control=1, which gives DataOutput=input 1 and SelError=0.
  - Without the macro → DataOutput=input 0, Valid=1, SelError=0.
- Assert RstN=0 between clock edges while tracking → DataOutput, Valid and SelError go to 0 before the next edge. After release, outputs stay 0 until a Load.
